// File: rtl/gcd_sched.sv
`default_nettype none
// ============================================================================
// Module      : gcd_sched
// Description : Round-robin scheduler that shares a single iterative GCD
//               engine between NREQ requesters. It grants one requester,
//               captures its operands, pulses the engine start, waits for
//               done (guarded by a watchdog) and returns a tagged response.
//
// Ports       : clk         - system clock, all logic on posedge
//               reset       - synchronous active-high reset
//               req_valid   - per-requester request, held until its response
//               req_opa     - packed operand A, requester i on [32i+31:32i]
//               req_opb     - packed operand B, same packing
//               eng_start   - one-cycle start pulse to the engine
//               eng_opa     - operand A to the engine, held for the transaction
//               eng_opb     - operand B to the engine, held for the transaction
//               eng_done    - engine completion, only honoured while waiting
//               eng_result  - engine result, valid with eng_done
//               rsp_valid   - one-cycle response pulse
//               rsp_id      - index of the requester being answered
//               rsp_result  - GCD result, 0 on watchdog abort
//               rsp_err     - watchdog abort flag, qualified by rsp_valid
//               busy        - high in every state except idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [32*NREQ-1:0]     req_opa,
    input  logic [32*NREQ-1:0]     req_opb,
    output logic                   eng_start,
    output logic [31:0]            eng_opa,
    output logic [31:0]            eng_opb,
    input  logic                   eng_done,
    input  logic [31:0]            eng_result,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [31:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   busy
);

    // Watchdog counter just wide enough to hold TIMEOUT.
    localparam int c_TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_grant_id;
    logic [c_TW-1:0] r_timer;
    logic            r_eng_start;
    logic [31:0]     r_eng_opa;
    logic [31:0]     r_eng_opb;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [31:0]     r_rsp_result;
    logic            r_rsp_err;
    logic            r_busy;

    logic [31:0]     w_opa_arr [NREQ];
    logic [31:0]     w_opb_arr [NREQ];
    logic            w_gnt_found;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_scan_idx;
    logic [IDW-1:0]  w_next_ptr;
    logic            w_timeout;

    // Unpack the flat operand buses so the grant index can select directly.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_opa_arr[gi] = req_opa[32*gi +: 32];
            assign w_opb_arr[gi] = req_opb[32*gi +: 32];
        end
    endgenerate

    // Round-robin pick: scan offsets from the highest down so that the
    // smallest offset from r_rr_ptr with a pending request wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scan_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (req_valid[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    // Pointer moves just past the requester that was served; explicit wrap
    // keeps this correct when NREQ is not a power of two.
    assign w_next_ptr = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_timeout  = (r_timer == c_TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_timer      <= '0;
            r_eng_start  <= 1'b0;
            r_eng_opa    <= '0;
            r_eng_opb    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Both pulses last exactly one cycle unless re-armed below.
            r_eng_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_gnt_found) begin
                        r_grant_id  <= w_gnt_idx;
                        r_eng_opa   <= w_opa_arr[w_gnt_idx];
                        r_eng_opb   <= w_opb_arr[w_gnt_idx];
                        r_eng_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_timer <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // Done is checked first so it wins over a same-cycle timeout.
                    if (eng_done) begin
                        r_rsp_result <= eng_result;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_grant_id;
                        r_state      <= c_RESP;
                    end else if (w_timeout) begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_grant_id;
                        r_state      <= c_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_RESP: begin
                    r_rr_ptr <= w_next_ptr;
                    r_busy   <= 1'b0;
                    r_state  <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign eng_start  = r_eng_start;
    assign eng_opa    = r_eng_opa;
    assign eng_opb    = r_eng_opb;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gcd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_sched
// Description : Directed self-checking bench for gcd_sched. The bench plays
//               the role of both the requesters and the GCD engine, with
//               hand-computed results. Inputs change and outputs are sampled
//               on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 1023;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_opa;
    logic [32*NREQ-1:0]  req_opb;
    logic                eng_start;
    logic [31:0]         eng_opa;
    logic [31:0]         eng_opb;
    logic                eng_done;
    logic [31:0]         eng_result;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_result;
    logic                rsp_err;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;

    gcd_sched #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .eng_start  (eng_start),
        .eng_opa    (eng_opa),
        .eng_opb    (eng_opb),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_opa[32*id +: 32] = a;
        req_opb[32*id +: 32] = b;
        req_valid[id]        = 1'b1;
    endtask

    // Called at a falling edge while the DUT is idle with id's request being
    // the next one granted. Engine answers 'res' in the lat-th wait cycle.
    // The requester scrambles its operands during the wait to prove they
    // were captured at grant.
    task automatic run_txn(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int lat);
        @(negedge clk);
        check("issue_start", 32'(eng_start), 1);
        check("issue_opa", eng_opa, a);
        check("issue_opb", eng_opb, b);
        check("issue_busy", 32'(busy), 1);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("start_pulse", 32'(eng_start), 0);
                req_opa[32*id +: 32] = ~a;
                req_opb[32*id +: 32] = ~b;
            end
            if (i == lat) begin
                eng_done   = 1'b1;
                eng_result = res;
            end
        end
        @(negedge clk);
        eng_done   = 1'b0;
        eng_result = 32'hFFFF_FFFF;
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_result", rsp_result, res);
        check("rsp_err", 32'(rsp_err), 0);
        check("opa_stable", eng_opa, a);
        check("opb_stable", eng_opb, b);
        req_valid[id] = 1'b0;
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    // Engine stays silent for TIMEOUT+1 wait cycles; with 'coincide' set it
    // answers in the very cycle the watchdog expires.
    task automatic run_timeout(input int id, input logic [31:0] a, input logic [31:0] b,
                               input bit coincide, input logic [31:0] res);
        bit early;
        early = 1'b0;
        @(negedge clk);
        check("to_issue_start", 32'(eng_start), 1);
        check("to_issue_opa", eng_opa, a);
        check("to_issue_opb", eng_opb, b);
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            @(negedge clk);
            if (rsp_valid || !busy) early = 1'b1;
            if (coincide && i == TIMEOUT + 1) begin
                eng_done   = 1'b1;
                eng_result = res;
            end
        end
        check("to_no_early_rsp", 32'(early), 0);
        @(negedge clk);
        eng_done   = 1'b0;
        eng_result = 32'hFFFF_FFFF;
        check("to_rsp_valid", 32'(rsp_valid), 1);
        check("to_rsp_id", 32'(rsp_id), 32'(id));
        check("to_rsp_err", 32'(rsp_err), coincide ? 0 : 1);
        check("to_rsp_result", rsp_result, coincide ? res : 0);
        req_valid[id] = 1'b0;
        @(negedge clk);
        check("to_rsp_pulse", 32'(rsp_valid), 0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_opa    = '0;
        req_opb    = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_eng_start", 32'(eng_start), 0);
        check("rst_eng_opa", eng_opa, 0);
        check("rst_eng_opb", eng_opb, 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        reset = 1'b0;

        // Stray done while idle must be ignored.
        eng_done   = 1'b1;
        eng_result = 32'd99;
        @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
        check("idle_done_no_rsp", 32'(rsp_valid), 0);
        check("idle_done_no_busy", 32'(busy), 0);

        // Single request from requester 2.
        set_req(2, 32'd48, 32'd18);
        run_txn(2, 32'd48, 32'd18, 32'd6, 5);

        // Contention from a fresh reset: grants rotate 0,1,2,3.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 32'd12, 32'd8);
        set_req(1, 32'd35, 32'd14);
        set_req(2, 32'd81, 32'd27);
        set_req(3, 32'd17, 32'd5);
        run_txn(0, 32'd12, 32'd8,  32'd4,  3);
        run_txn(1, 32'd35, 32'd14, 32'd7,  2);
        run_txn(2, 32'd81, 32'd27, 32'd27, 4);
        run_txn(3, 32'd17, 32'd5,  32'd1,  1);
        set_req(0, 32'd100, 32'd75);
        set_req(3, 32'd21,  32'd14);
        run_txn(0, 32'd100, 32'd75, 32'd25, 2);
        run_txn(3, 32'd21,  32'd14, 32'd7,  2);

        // Watchdog abort, then a normal transaction.
        set_req(1, 32'd9, 32'd6);
        run_timeout(1, 32'd9, 32'd6, 1'b0, 32'd0);
        set_req(2, 32'd10, 32'd4);
        run_txn(2, 32'd10, 32'd4, 32'd2, 2);

        // Done arriving exactly at the watchdog limit wins.
        set_req(0, 32'd27, 32'd18);
        run_timeout(0, 32'd27, 32'd18, 1'b1, 32'd9);

        // Move the pointer to 3, then reset during the wait for requester 3.
        set_req(2, 32'd64, 32'd48);
        run_txn(2, 32'd64, 32'd48, 32'd16, 1);
        set_req(3, 32'd91, 32'd65);
        set_req(1, 32'd45, 32'd30);
        @(negedge clk);
        check("pre_rst_grant_opa", eng_opa, 32'd91);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_eng_start", 32'(eng_start), 0);
        reset = 1'b0;
        // Pointer is back at 0, so requester 1 goes ahead of requester 3.
        run_txn(1, 32'd45, 32'd30, 32'd15, 3);
        run_txn(3, 32'd91, 32'd65, 32'd13, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
- Round-robin scheduler that shares one iterative Euclidean GCD engine between NREQ requesters.
- Captures a requester's operands, drives the engine's start/operand interface, waits for engine done, and returns the result tagged with the requester index.
- Includes a watchdog that aborts a hung engine operation and reports an error response.
- Sits between client blocks and the single GCD datapath instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester index width, equal to clog2(NREQ)
TIMEOUT, 1023, maximum WAIT cycles before abort (fits in 10-bit counter)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester request, held high until that requester's rsp_valid
req_opa  input  32*NREQ  operand A, requester i on bits [32i+31:32i]
req_opb  input  32*NREQ  operand B, same packing
eng_start  output  1  one-cycle start pulse to GCD engine
eng_opa  output  32  operand A to engine, stable from start until done
eng_opb  output  32  operand B to engine, stable from start until done
eng_done  input  1  engine completion, sampled only in WAIT
eng_result  input  32  engine result, valid when eng_done=1
rsp_valid  output  1  one-cycle response pulse
rsp_id  output  IDW  index of requester being answered
rsp_result  output  32  GCD result; 0 on error
rsp_err  output  1  1 = timeout abort, qualified by rsp_valid
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: eng_start=0, eng_opa=0, eng_opb=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0, state=IDLE, rr_ptr=0, timer=0.
- Reset mid-operation returns to IDLE the next cycle. No response is issued. The engine is not notified.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - Latch the selected index into grant_id and latch its req_opa/req_opb into eng_opa/eng_opb.
  - Go to ISSUE.
- ISSUE:
  - eng_start=1 for exactly this cycle.
  - timer cleared. Go to WAIT.
- WAIT:
  - If eng_done=1: latch eng_result into rsp_result, rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT: rsp_result=0, rsp_err=1, go to RESP.
  - Otherwise timer increments.
  - If eng_done and the timeout coincide, done wins.
- RESP:
  - rsp_valid=1 and rsp_id=grant_id for exactly this cycle.
  - rr_ptr = grant_id+1, wrapping to 0 after NREQ-1.
  - Go to IDLE.
- Latency:
  - Request seen in IDLE at cycle t: eng_start at t+1.
  - Engine done at cycle d: rsp_valid at d+1.
  - Next grant is possible at d+2 (IDLE).
- Operands are captured once at grant. Later changes on req_opa/req_opb are ignored for that transaction.
- A requester must deassert req_valid the cycle after its rsp_valid. If it is still high in IDLE, it is treated as a new request.
- req_valid dropping before grant: the request is silently withdrawn.
- Operand zero handling is the engine's responsibility. The scheduler passes all values, including 0,0, unchanged.
- eng_done outside WAIT is ignored.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0 with no requester skipped.
- Outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Single request:
  - Stimulus: requester 2 sends opa=48, opb=18; engine model answers 6 after 5 WAIT cycles.
  - Expected: eng_start one cycle after req, eng_opa=48, eng_opb=18, rsp_valid with rsp_id=2, rsp_result=6, rsp_err=0.
- All-requester contention:
  - Stimulus: all 4 requesters request simultaneously after reset, operands (12,8), (35,14), (81,27), (17,5).
  - Expected: responses in order id 0,1,2,3 with results 4, 7, 27, 1.
  - Re-assert requester 0 and 3 only: expected order 0 then 3, or per rr_ptr.
- Timeout:
  - Stimulus: engine model never asserts done.
  - Expected: rsp_valid exactly TIMEOUT+1 cycles after entering WAIT, rsp_err=1, rsp_result=0.
  - The next request is then served normally.
- Done/timeout coincidence:
  - Stimulus: eng_done asserted in the cycle timer==TIMEOUT with result 9.
  - Expected: rsp_err=0, rsp_result=9.
- Reset mid-WAIT:
  - Stimulus: assert reset during WAIT.
  - Expected: next cycle busy=0, no rsp_valid. rr_ptr=0, so the lowest pending index is granted first.
- Operand stability:
  - Stimulus: change req_opa of the granted requester during WAIT.
  - Expected: eng_opa unchanged until rsp_valid.
